bcd_alu_seq: RTL and testbench

- Multi-cycle, parametrised BCD arithmetic unit for the calculator datapath. Sits between the operand entry registers and the display driver.
- Accepts two DIGITS-digit packed-BCD operands plus an operation code, then runs three stages: sequential BCD-to-binary conversion, sequential execute, sequential double-dabble back to BCD.
- Adds a start/busy/done handshake, saturation with an overflow flag, invalid-digit/op error flag, and an optional sequential multiplier.

---
 rtl/bcd_alu_seq.sv | 269 ++++++++++++++++++++++++++
 tb/tb_bcd_alu_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_alu_seq.sv
// bcd_alu_seq
//   Multi-cycle packed-BCD arithmetic unit for the calculator datapath.
//   Operands are converted to binary (Horner, MSD first), the operation is
//   executed in binary, then the result is converted back to BCD by a fixed
//   length double-dabble pass.
//
//   Optional feature macro: MUL_EN
//     defined   -> op 4'b0100 runs a shift-add sequential multiplier
//     undefined -> op 4'b0100 is treated as an unsupported op code
//
// Ports
//   clk            rising-edge clock
//   clear_n        asynchronous active-low reset; aborts any operation
//   start          request, sampled only in IDLE
//   bcd1, bcd2     packed BCD operands, most significant digit in top nibble
//   op_selected    4'b0001 add, 4'b0010 |A-B|, 4'b0100 multiply (MUL_EN)
//   bcd_out        packed BCD result (all 9s when saturated, 0 on error)
//   special_signal subtract result was negative (B > A)
//   overflow       result exceeded 10^DIGITS-1 and was saturated
//   err            invalid BCD digit or unsupported op code
//   busy           high from accepted start through the DONE cycle
//   done           one-cycle pulse when the result outputs update
module bcd_alu_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd1,
  input  logic [4*DIGITS-1:0] bcd2,
  input  logic [3:0]          op_selected,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                special_signal,
  output logic                overflow,
  output logic                err,
  output logic                busy,
  output logic                done
);

  localparam int unsigned BW    = 4 * DIGITS;
  localparam int unsigned RW    = 2 * BIN_W;
  localparam int unsigned CNT_W = $clog2(RW) + 1;

  localparam logic [RW-1:0]    MAX_R     = RW'(10 ** DIGITS - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] B2B_LAST  = CNT_W'(RW - 1);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
`ifdef MUL_EN
  localparam logic [3:0]       OP_MUL   = 4'b0100;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(BIN_W - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_EXEC,
    S_B2B,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BW-1:0]    a_sh;
  logic [BW-1:0]    b_sh;
  logic [3:0]       op_r;
  logic [BIN_W-1:0] acc_a;
  logic [BIN_W-1:0] acc_b;
  logic             err_f;
  logic             neg_f;
  logic             ovf_f;
  logic [RW-1:0]    res;
  logic [BW-1:0]    bcd_sh;
`ifdef MUL_EN
  logic [RW-1:0]    mcand;
  logic [BIN_W-1:0] mplier;
`endif

  // Horner step: take the top nibble of each shifting operand register.
  logic [3:0]       raw_a;
  logic [3:0]       raw_b;
  logic             bad_a;
  logic             bad_b;
  logic [BIN_W-1:0] acc_a_nxt;
  logic [BIN_W-1:0] acc_b_nxt;

  always_comb begin
    raw_a     = a_sh[BW-1 -: 4];
    raw_b     = b_sh[BW-1 -: 4];
    bad_a     = (raw_a > 4'd9);
    bad_b     = (raw_b > 4'd9);
    // acc*10 = acc*8 + acc*2; an invalid digit contributes 0.
    acc_a_nxt = (acc_a << 3) + (acc_a << 1) + BIN_W'(bad_a ? 4'd0 : raw_a);
    acc_b_nxt = (acc_b << 3) + (acc_b << 1) + BIN_W'(bad_b ? 4'd0 : raw_b);
  end

  // Execute-stage datapath.
  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic          a_lt_b;
  logic [RW-1:0] exec_val;
  logic          exec_neg;
  logic          exec_bad;
  logic          exec_ovf;
  logic [RW-1:0] sat_val;
  logic          exec_wait;
`ifdef MUL_EN
  logic [RW-1:0] prod_nxt;
`endif

  always_comb begin
    a_ext  = RW'(acc_a);
    b_ext  = RW'(acc_b);
    a_lt_b = (acc_a < acc_b);
`ifdef MUL_EN
    prod_nxt  = res + (mplier[0] ? mcand : '0);
    exec_wait = (op_r == OP_MUL) && (cnt != MUL_LAST);
`else
    exec_wait = 1'b0;
`endif
    exec_val = '0;
    exec_neg = 1'b0;
    exec_bad = 1'b0;
    case (op_r)
      OP_ADD: exec_val = a_ext + b_ext;
      OP_SUB: begin
        exec_val = a_lt_b ? (b_ext - a_ext) : (a_ext - b_ext);
        exec_neg = a_lt_b;
      end
`ifdef MUL_EN
      // Final multiplier step folds in the last partial product.
      OP_MUL: exec_val = prod_nxt;
`endif
      default: exec_bad = 1'b1;
    endcase
    exec_ovf = (exec_val > MAX_R);
    sat_val  = exec_ovf ? MAX_R : exec_val;
  end

  // Double-dabble step: correct every nibble >= 5, then shift in next R bit.
  logic [BW-1:0] bcd_adj;
  logic [BW-1:0] bcd_nxt;

  always_comb begin
    bcd_adj = bcd_sh;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
      end
    end
    bcd_nxt = (bcd_adj << 1) | BW'(res[RW-1]);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      a_sh           <= '0;
      b_sh           <= '0;
      op_r           <= '0;
      acc_a          <= '0;
      acc_b          <= '0;
      err_f          <= 1'b0;
      neg_f          <= 1'b0;
      ovf_f          <= 1'b0;
      res            <= '0;
      bcd_sh         <= '0;
`ifdef MUL_EN
      mcand          <= '0;
      mplier         <= '0;
`endif
      bcd_out        <= '0;
      special_signal <= 1'b0;
      overflow       <= 1'b0;
      err            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= bcd1;
            b_sh  <= bcd2;
            op_r  <= op_selected;
            acc_a <= '0;
            acc_b <= '0;
            err_f <= 1'b0;
            neg_f <= 1'b0;
            ovf_f <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_CONV;
          end
        end

        S_CONV: begin
          acc_a <= acc_a_nxt;
          acc_b <= acc_b_nxt;
          a_sh  <= a_sh << 4;
          b_sh  <= b_sh << 4;
          err_f <= err_f | bad_a | bad_b;
          if (cnt == CONV_LAST) begin
            cnt   <= '0;
            res   <= '0;
`ifdef MUL_EN
            mcand  <= RW'(acc_a_nxt);
            mplier <= acc_b_nxt;
`endif
            state <= S_EXEC;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_EXEC: begin
          if (exec_wait) begin
            cnt <= cnt + CNT_W'(1);
`ifdef MUL_EN
            res    <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
`endif
          end else begin
            // Any error forces a zero result so the B2B pass stays fixed-length.
            if (exec_bad || err_f) begin
              res   <= '0;
              neg_f <= 1'b0;
              ovf_f <= 1'b0;
              err_f <= 1'b1;
            end else begin
              res   <= sat_val;
              neg_f <= exec_neg;
              ovf_f <= exec_ovf;
            end
            cnt    <= '0;
            bcd_sh <= '0;
            state  <= S_B2B;
          end
        end

        S_B2B: begin
          bcd_sh <= bcd_nxt;
          res    <= res << 1;
          if (cnt == B2B_LAST) begin
            bcd_out        <= err_f ? '0 : bcd_nxt;
            special_signal <= neg_f & ~err_f;
            overflow       <= ovf_f & ~err_f;
            err            <= err_f;
            done           <= 1'b1;
            state          <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_alu_seq.sv
module tb_bcd_alu_seq;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bcd1 = '0;
  logic [15:0] bcd2 = '0;
  logic [3:0]  op_selected = '0;
  logic [15:0] bcd_out;
  logic        special_signal;
  logic        overflow;
  logic        err;
  logic        busy;
  logic        done;

  bcd_alu_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk            (clk),
    .clear_n        (clear_n),
    .start          (start),
    .bcd1           (bcd1),
    .bcd2           (bcd2),
    .op_selected    (op_selected),
    .bcd_out        (bcd_out),
    .special_signal (special_signal),
    .overflow       (overflow),
    .err            (err),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic        neg;
    logic        ovf;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned done_cnt = 0;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal arithmetic on the operands' decimal values.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    exp_t e;
    int unsigned va, vb, r;
    bit bad;
    logic [3:0] d;
    e = '0; va = 0; vb = 0; r = 0; bad = 0;
    for (int i = 3; i >= 0; i--) begin
      d = a[4*i +: 4];
      if (d > 4'd9) bad = 1;
      va = va * 10 + ((d > 4'd9) ? 0 : 32'(d));
      d = b[4*i +: 4];
      if (d > 4'd9) bad = 1;
      vb = vb * 10 + ((d > 4'd9) ? 0 : 32'(d));
    end
    e.lat = 34;
`ifdef MUL_EN
    if (op == 4'b0100) e.lat = 47;
`endif
    case (op)
      4'b0001: r = va + vb;
      4'b0010: begin
        if (va >= vb) r = va - vb;
        else begin r = vb - va; e.neg = 1'b1; end
      end
`ifdef MUL_EN
      4'b0100: r = va * vb;
`endif
      default: bad = 1;
    endcase
    if (r > 9999) begin r = 9999; e.ovf = 1'b1; end
    for (int i = 0; i < 4; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    if (bad) begin
      e.bcd = '0; e.neg = 1'b0; e.ovf = 1'b0; e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input bit poke10);
    exp_t e, got_e;
    int unsigned c;
    bit seen, busy_lo;
    logic [15:0] prev;
    sb.push_back(model(a, b, op));
    prev = bcd_out;
    @(negedge clk);
    bcd1 = a; bcd2 = b; op_selected = op; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    c = 1; seen = 0; busy_lo = 0;
    while (!seen && c <= 100) begin
      if (done) begin
        seen = 1;
        if (sb.size() == 0) begin
          check("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
          got_e = sb.pop_front();
          e = got_e;
          check("latency", c, e.lat);
          check("bcd_out", 32'(bcd_out), 32'(e.bcd));
          check("special", 32'(special_signal), 32'(e.neg));
          check("overflow", 32'(overflow), 32'(e.ovf));
          check("err", 32'(err), 32'(e.err));
          check("busy_done", 32'(busy), 32'd1);
        end
      end else begin
        if (!busy) busy_lo = 1;
        if (c == 10) check("hold", 32'(bcd_out), 32'(prev));
        if (poke10 && c == 10) begin bcd1 = 16'h9999; start = 1'b1; end
        if (poke10 && c == 11) start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("busy_run", 32'(busy_lo), 32'd0);
    check("busy_clr", 32'(busy), 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0;
    logic [15:0] ra, rb;

    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_flags", 32'({special_signal, overflow, err}), 32'd0);
    check("rst_busy", 32'({busy, done}), 32'd0);
    clear_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 4'b0001, 0);
    run_op(16'h0100, 16'h0250, 4'b0010, 0);
    run_op(16'h0250, 16'h0100, 4'b0010, 0);
    run_op(16'h0012, 16'h0034, 4'b0100, 0);
    run_op(16'h0200, 16'h0050, 4'b0100, 0);
    run_op(16'h12A4, 16'h0001, 4'b0001, 0);
    run_op(16'h0003, 16'h0004, 4'b1000, 0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(9));
        rb[4*i +: 4] = 4'($urandom_range(9));
      end
      run_op(ra, rb, (k % 2 == 0) ? 4'b0001 : 4'b0010, 0);
    end

    // Restart request while busy must be ignored.
    d0 = done_cnt;
    run_op(16'h0005, 16'h0007, 4'b0001, 1);
    repeat (45) @(negedge clk);
    check("one_done", done_cnt - d0, 32'd1);
    check("ignored_start", 32'(bcd_out), 32'h0012);

    // Leave nonzero outputs, then abort an operation with clear_n.
    run_op(16'h9999, 16'h0001, 4'b0001, 0);
    d0 = done_cnt;
    @(negedge clk);
    bcd1 = 16'h1234; bcd2 = 16'h4321; op_selected = 4'b0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 clear_n = 1'b0;
    #1;
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_flags", 32'({special_signal, overflow, err}), 32'd0);
    check("abort_busy", 32'({busy, done}), 32'd0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    repeat (50) @(negedge clk);
    check("abort_nodone", done_cnt - d0, 32'd0);

    run_op(16'h0250, 16'h0100, 4'b0010, 0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
